// File: rtl/s2p_pkg.sv
// Shared definitions for the serial-to-parallel byte deserialiser.
package s2p_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

endpackage

// File: rtl/serial_to_parallel_8_comma_detect.sv
// Combinational match of the current 8-bit window against the comma character.
module comma_detect
    import s2p_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA = COMMA_DEFAULT
) (
    input  logic [BYTE_W-1:0] win,
    output logic              match
);

    assign match = (win == COMMA);

endmodule

// File: rtl/serial_to_parallel_8.sv
// Bit-serial to byte deserialiser: hunts for comma alignment, locks, then presents bytes.
module serial_to_parallel_8
    import s2p_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA       = COMMA_DEFAULT,
    parameter int unsigned       COMMA_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
);

    localparam logic [3:0] CNT_TARGET = 4'(COMMA_COUNT);

    state_t            state, state_nx;
    logic [BYTE_W-1:0] sr;
    logic [BYTE_W-1:0] win;
    logic [2:0]        bit_cnt, bit_cnt_nx;
    logic [3:0]        comma_cnt, comma_cnt_nx, comma_inc;
    logic [BYTE_W-1:0] data_nx;
    logic              valid_nx;
    logic              active_nx;
    logic              is_comma;
    logic              boundary;

    // The window includes the bit arriving on this edge, so a match is seen
    // on the very edge that samples a comma's last bit.
    assign win       = {sr[BYTE_W-2:0], data_in};
    assign boundary  = (bit_cnt == 3'd7);
    assign comma_inc = sat_inc4(comma_cnt);

    comma_detect #(
        .COMMA (COMMA)
    ) u_comma_detect (
        .win   (win),
        .match (is_comma)
    );

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        comma_cnt_nx = comma_cnt;
        data_nx      = data_out;
        valid_nx     = valid_out;
        active_nx    = active;

        case (state)
            HUNT: begin
                if (is_comma) begin
                    bit_cnt_nx   = '0;
                    comma_cnt_nx = 4'd1;
                    if (COMMA_COUNT == 1) begin
                        state_nx  = ACTIVE;
                        active_nx = 1'b1;
                    end else begin
                        state_nx = LOCK;
                    end
                end
            end
            LOCK: begin
                bit_cnt_nx = bit_cnt + 3'd1;
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_nx = comma_inc;
                        if (comma_inc == CNT_TARGET) begin
                            state_nx  = ACTIVE;
                            active_nx = 1'b1;
                        end
                    end else begin
                        comma_cnt_nx = '0;
                        state_nx     = HUNT;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_nx = bit_cnt + 3'd1;
                if (boundary) begin
                    data_nx  = win;
                    valid_nx = !is_comma;
                end
            end
            default: begin
                state_nx = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nx;
            sr        <= win;
            bit_cnt   <= bit_cnt_nx;
            comma_cnt <= comma_cnt_nx;
            data_out  <= data_nx;
            valid_out <= valid_nx;
            active    <= active_nx;
        end
    end

endmodule
